// File: rtl/div_wb_pkg.sv
// Shared types and constants for the div_wb write-back divider.
package div_wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

  localparam int unsigned DivCycles = 32;
  localparam logic [31:0] DivZeroQ  = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DIV_W = 32
) (
  input  logic [DIV_W:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W:0]   rem_out,
  output logic             q_bit
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W:0]   diff;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = shifted >= {2'b00, divisor};
    diff    = shifted[DIV_W:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[DIV_W:0];
  end

endmodule

// File: rtl/div_wb.sv
// Multi-cycle 32-bit divider with a single-cycle regfile write-back pulse.
// Define DIV_SIGNED_EN to enable signed operation (op_signed); otherwise all ops are unsigned.
module div_wb
  import div_wb_pkg::*;
#(
  parameter int unsigned DIV_W = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_rem,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic [4:0]       dst_addr,
  input  logic             annul,
  output logic             busy,
  output logic             wreg,
  output logic [4:0]       waddr,
  output logic [DIV_W-1:0] wdata,
  output logic             div_zero
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W:0]   rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] dvs_q;
  logic             rem_sel_q;
  logic [4:0]       addr_q;
  logic             neg_q_q;
  logic             neg_r_q;

  logic [DIV_W:0]   rem_next;
  logic             q_bit;
  logic [DIV_W-1:0] dvd_mag, dvs_mag;
  logic [DIV_W-1:0] q_raw, r_raw, q_fin, r_fin;
  logic             dvd_neg, dvs_neg;
  logic             unused_bits;

  div_step #(
    .DIV_W(DIV_W)
  ) u_step (
    .rem_in (rem_q),
    .dvd_bit(quo_q[DIV_W-1]),
    .divisor(dvs_q),
    .rem_out(rem_next),
    .q_bit  (q_bit)
  );

  // The dividend register doubles as the quotient shift register.
  assign q_raw = {quo_q[DIV_W-2:0], q_bit};
  assign r_raw = rem_next[DIV_W-1:0];

`ifdef DIV_SIGNED_EN
  always_comb begin
    dvd_neg     = op_signed & dividend[DIV_W-1];
    dvs_neg     = op_signed & divisor[DIV_W-1];
    dvd_mag     = dvd_neg ? neg32(dividend) : dividend;
    dvs_mag     = dvs_neg ? neg32(divisor) : divisor;
    q_fin       = neg_q_q ? neg32(q_raw) : q_raw;
    r_fin       = neg_r_q ? neg32(r_raw) : r_raw;
    unused_bits = rem_next[DIV_W];
  end
`else
  always_comb begin
    dvd_neg     = 1'b0;
    dvs_neg     = 1'b0;
    dvd_mag     = dividend;
    dvs_mag     = divisor;
    q_fin       = q_raw;
    r_fin       = r_raw;
    unused_bits = rem_next[DIV_W] ^ op_signed ^ neg_q_q ^ neg_r_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      addr_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      busy      <= 1'b0;
      wreg      <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      div_zero  <= 1'b0;
    end else begin
      wreg     <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      div_zero <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !annul) begin
            rem_sel_q <= op_rem;
            addr_q    <= dst_addr;
            neg_q_q   <= dvd_neg ^ dvs_neg;
            neg_r_q   <= dvd_neg;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            if (divisor == '0) begin
              // Zero divisor skips iteration; remainder is the raw dividend.
              state_q  <= StDone;
              div_zero <= 1'b1;
              wreg     <= dst_addr != 5'd0;
              waddr    <= dst_addr;
              wdata    <= (dst_addr == 5'd0) ? '0 : (op_rem ? dividend : DivZeroQ);
            end else begin
              state_q <= StCalc;
              busy    <= 1'b1;
            end
          end
        end
        StCalc: begin
          if (annul) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            rem_q <= rem_next;
            quo_q <= q_raw;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DivCycles - 1)) begin
              state_q <= StDone;
              busy    <= 1'b0;
              wreg    <= addr_q != 5'd0;
              waddr   <= addr_q;
              wdata   <= (addr_q == 5'd0) ? '0 : (rem_sel_q ? r_fin : q_fin);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_wb.sv
// Directed self-checking bench for div_wb: vector table plus annul/stall/reset sequences.
module tb_div_wb;

`ifdef DIV_SIGNED_EN
  localparam bit SgnEn = 1'b1;
`else
  localparam bit SgnEn = 1'b0;
`endif

  localparam logic [63:0] BusyCalc = 64'h0000_0001_FFFF_FFFE;  // cycles 1..32

  logic        clk = 1'b0;
  logic        rst, start, op_signed, op_rem, annul;
  logic [31:0] dividend, divisor;
  logic [4:0]  dst_addr;
  logic        busy, wreg, div_zero;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  div_wb dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_signed(op_signed),
    .op_rem   (op_rem),
    .dividend (dividend),
    .divisor  (divisor),
    .dst_addr (dst_addr),
    .annul    (annul),
    .busy     (busy),
    .wreg     (wreg),
    .waddr    (waddr),
    .wdata    (wdata),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic        rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
    logic [31:0] res;
    int          wcyc;   // 0 = no write pulse expected
    int          dzcyc;  // 0 = no div_zero pulse expected
    logic [63:0] bmap;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] busy_map;
  int          wreg_cnt, wreg_cyc, dz_cnt, dz_cyc, leak;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    busy_map = '0;
    wreg_cnt = 0;
    wreg_cyc = 0;
    dz_cnt   = 0;
    dz_cyc   = 0;
    leak     = 0;
    w_addr   = '0;
    w_data   = '0;
  endtask

  // Samples outputs at the current falling edge for n cycles, numbered from c0.
  task automatic watch(input int n, input int c0);
    for (int k = 0; k < n; k++) begin
      if (busy === 1'b1 && (c0 + k) < 64) busy_map[c0+k] = 1'b1;
      if (wreg === 1'b1) begin
        wreg_cnt++;
        wreg_cyc = c0 + k;
        w_addr   = waddr;
        w_data   = wdata;
      end
      if (div_zero === 1'b1) begin
        dz_cnt++;
        dz_cyc = c0 + k;
      end
      if (!(wreg === 1'b1 || div_zero === 1'b1) && (waddr !== 5'd0 || wdata !== 32'd0)) leak++;
      @(negedge clk);
    end
  endtask

  // Called at a falling edge; start is sampled at the next rising edge (edge 0).
  task automatic issue(input logic sgn, input logic rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr);
    op_signed = sgn;
    op_rem    = rm;
    dividend  = a;
    divisor   = b;
    dst_addr  = addr;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic vec_t mk(input logic sgn, input logic rm, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] addr,
                              input logic [31:0] res, input int wcyc, input int dzcyc,
                              input logic [63:0] bmap);
    vec_t v;
    v.sgn = sgn; v.rm = rm; v.a = a; v.b = b; v.addr = addr; v.res = res;
    v.wcyc = wcyc; v.dzcyc = dzcyc; v.bmap = bmap;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    vecs[0]  = mk(0, 0, 32'd100, 32'd7, 5'd5, 32'd14, 33, 0, BusyCalc);
    vecs[1]  = mk(0, 1, 32'd100, 32'd7, 5'd6, 32'd2, 33, 0, BusyCalc);
    vecs[2]  = mk(1, 0, 32'hFFFF_FF9C, 32'd7, 5'd7,
                  SgnEn ? 32'hFFFF_FFF2 : 32'h2492_4916, 33, 0, BusyCalc);
    vecs[3]  = mk(1, 1, 32'hFFFF_FF9C, 32'd7, 5'd8,
                  SgnEn ? 32'hFFFF_FFFE : 32'd2, 33, 0, BusyCalc);
    vecs[4]  = mk(0, 1, 32'd5, 32'd0, 5'd9, 32'd5, 1, 1, 64'd0);
    vecs[5]  = mk(0, 0, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 1, 64'd0);
    vecs[6]  = mk(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
                  SgnEn ? 32'h8000_0000 : 32'd0, 33, 0, BusyCalc);
    vecs[7]  = mk(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12,
                  SgnEn ? 32'd0 : 32'h8000_0000, 33, 0, BusyCalc);
    vecs[8]  = mk(0, 0, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, 33, 0, BusyCalc);
    vecs[9]  = mk(0, 1, 32'h1234_5678, 32'd1000, 5'd14, 32'h380, 33, 0, BusyCalc);
    vecs[10] = mk(1, 0, 32'd100, 32'hFFFF_FFF9, 5'd15,
                  SgnEn ? 32'hFFFF_FFF2 : 32'd0, 33, 0, BusyCalc);
    vecs[11] = mk(0, 0, 32'd7, 32'd100, 5'd16, 32'd0, 33, 0, BusyCalc);
    vecs[12] = mk(0, 0, 32'd100, 32'd7, 5'd0, 32'd0, 0, 0, BusyCalc);
    vecs[13] = mk(0, 1, 32'd5, 32'd0, 5'd0, 32'd0, 0, 1, 64'd0);
    vecs[14] = mk(0, 0, 32'd0, 32'd5, 5'd31, 32'd0, 33, 0, BusyCalc);

    rst = 1'b1; start = 1'b0; annul = 1'b0; op_signed = 1'b0; op_rem = 1'b0;
    dividend = '0; divisor = '0; dst_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, wreg, waddr, wdata, div_zero}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Annul in cycle 10 (with a competing start), new request in cycle 11.
    clear_stats();
    issue(0, 0, 32'd100, 32'd7, 5'd5);
    watch(9, 1);
    annul = 1'b1;
    start = 1'b1;
    watch(1, 10);
    annul = 1'b0;
    dividend = 32'd200; divisor = 32'd9; dst_addr = 5'd3;
    watch(1, 11);
    start = 1'b0;
    watch(40, 12);
    chk("annul_busy_map", busy_map, 64'h0000_0FFF_FFFF_F7FE);
    chk("annul_wreg_cnt", wreg_cnt, 1);
    chk("annul_wreg_cyc", wreg_cyc, 44);
    chk("annul_waddr", w_addr, 3);
    chk("annul_wdata", w_data, 22);
    chk("annul_leak", leak, 0);

    // Start during CALC and during DONE must both be ignored.
    clear_stats();
    issue(0, 0, 32'd100, 32'd7, 5'd5);
    watch(4, 1);
    dividend = 32'd50; divisor = 32'd5; dst_addr = 5'd9; start = 1'b1;
    watch(1, 5);
    start = 1'b0;
    watch(27, 6);
    start = 1'b1;
    watch(1, 33);
    start = 1'b0;
    watch(10, 34);
    chk("ign_busy_map", busy_map, BusyCalc);
    chk("ign_wreg_cnt", wreg_cnt, 1);
    chk("ign_wreg_cyc", wreg_cyc, 33);
    chk("ign_waddr", w_addr, 5);
    chk("ign_wdata", w_data, 14);
    chk("ign_leak", leak, 0);

    // Reset asserted in cycle 20 of a CALC.
    clear_stats();
    issue(0, 0, 32'd100, 32'd7, 5'd5);
    watch(19, 1);
    rst = 1'b1;
    watch(1, 20);
    rst = 1'b0;
    chk("rst_mid_outputs", {busy, wreg, waddr, wdata, div_zero}, 64'd0);
    watch(30, 21);
    chk("rst_busy_map", busy_map, 64'h0000_0000_001F_FFFE);
    chk("rst_wreg_cnt", wreg_cnt, 0);
    chk("rst_dz_cnt", dz_cnt, 0);

    for (int i = 0; i < 15; i++) begin
      clear_stats();
      issue(vecs[i].sgn, vecs[i].rm, vecs[i].a, vecs[i].b, vecs[i].addr);
      watch(40, 1);
      chk($sformatf("v%0d_busy_map", i), busy_map, vecs[i].bmap);
      chk($sformatf("v%0d_wreg_cnt", i), wreg_cnt, (vecs[i].wcyc != 0) ? 1 : 0);
      if (vecs[i].wcyc != 0) begin
        chk($sformatf("v%0d_wreg_cyc", i), wreg_cyc, vecs[i].wcyc);
        chk($sformatf("v%0d_waddr", i), w_addr, vecs[i].addr);
        chk($sformatf("v%0d_wdata", i), w_data, vecs[i].res);
      end
      chk($sformatf("v%0d_dz_cnt", i), dz_cnt, (vecs[i].dzcyc != 0) ? 1 : 0);
      if (vecs[i].dzcyc != 0) chk($sformatf("v%0d_dz_cyc", i), dz_cyc, vecs[i].dzcyc);
      chk($sformatf("v%0d_leak", i), leak, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
